temp_code_encoder: RTL
======================

# temp_code_encoder

Switch-side producer of the 3-bit temperature-preset code consumed by the temperature-preventive decoders (`switchTempPreven` bus). It synchronizes the three raw board switches, debounces them, and presents a registered, glitch-free code together with a one-cycle change strobe. The decoders can then run from a code that changes only on clean, validated transitions.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable cycles required before a new code is accepted; legal range 1 … 2^CNT_W.
- `CNT_W`, default 5: debounce counter width; must hold DEB_CYCLES-1.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw_raw`  in  3  raw, asynchronous, bouncing switch inputs.
- `switchTempPreven`  out  3  registered, debounced temperature code; drives the decoder inputs.
- `code_stb`  out  1  one-cycle pulse in the cycle after `switchTempPreven` takes a new value.
- `busy`  out  1  high while a candidate code is being qualified or committed.

## Operation
- One clock domain, and one synchronous, active-high reset. Reset applies on the `clk` edge where `reset`=1.
- Reset values:
  - `switchTempPreven`=000, `code_stb`=0, `busy`=0.
  - Synchronizer flops=000, candidate=000, counter=0.
  - State=IDLE.
- Synchronizer: two flops, `sync1`<=`sw_raw`, then `sync2`<=`sync1`. The FSM uses only `sync2`.
- FSM states: IDLE, CHECK, COMMIT.
- IDLE:
  - If `sync2` ≠ `switchTempPreven`: candidate<=`sync2`, counter<=0, go to CHECK.
  - Otherwise stay in IDLE.
- CHECK, with `sync2` = candidate:
  - If counter = DEB_CYCLES-1: `switchTempPreven`<=candidate, go to COMMIT.
  - Otherwise counter<=counter+1.
- CHECK, with `sync2` ≠ candidate:
  - If `sync2` = `switchTempPreven`, the input bounced back: go to IDLE with no output change.
  - Otherwise: candidate<=`sync2`, counter<=0, stay in CHECK (counter restarts).
- COMMIT:
  - Lasts exactly one cycle, with `code_stb`=1.
  - `sync2` is not evaluated during this cycle.
  - Next state is always IDLE; any pending difference is picked up there.
- `busy` = (state ≠ IDLE). `code_stb` = (state = COMMIT). Both are decoded from the registered state.
- Counter never exceeds DEB_CYCLES-1 and never wraps.
- With DEB_CYCLES=1, the first CHECK cycle with a matching `sync2` commits.
- A `reset` asserted in any state overrides all other transitions. It forces the reset values on that edge, and no strobe is emitted for a discarded candidate.
- Multi-bit changes are treated as one candidate value; partial transitions restart qualification.

## Timing
- Edge 1 is the first rising edge sampling a new, stable `sw_raw`.
  - `sync2` holds the new value after edge 2.
  - The FSM enters CHECK at edge 3, so `busy` is high from edge 3.
- Latency: `switchTempPreven` updates at edge DEB_CYCLES+3 (edge 7 for the default).
  - `code_stb`=1 during the cycle following that edge.
  - The FSM returns to IDLE at edge DEB_CYCLES+4, where `busy` falls.
- Pulses on `sw_raw` shorter than DEB_CYCLES+1 cycles never reach the output.
- Minimum spacing between two strobes is DEB_CYCLES+2 cycles.
- Outputs are pure flops or registered-state decodes, with no combinational path from `sw_raw`.

## Test plan
All scenarios use DEB_CYCLES=4.
- Reset: hold `reset`=1 with `sw_raw`=111 for 3 cycles -> `switchTempPreven`=000, `code_stb`=0, `busy`=0 throughout.
- Clean change: `sw_raw` 000→100 held -> `busy` rises at edge 3, `switchTempPreven`=100 at edge 7, `code_stb` high for exactly one cycle, `busy` low after edge 8.
- Glitch: `sw_raw`=100 for 3 cycles then 000 -> `switchTempPreven` stays 000, no `code_stb`, `busy` pulses and returns low.
- Bounce: alternate 011/101 each cycle for 6 cycles, then hold 101 -> single commit of 101 exactly 7 edges after the final 101 sample, with one strobe and no intermediate 011.
- Mid-operation reset: assert `reset` for one edge during CHECK -> all outputs 000/0/0 after that edge, no strobe. A held `sw_raw` then re-qualifies with the full latency.
- Change during COMMIT: present a new value so that `sync2` changes during the COMMIT cycle -> that cycle ignores it, IDLE detects it next cycle, and a second commit follows with a second single strobe.

Source files
------------

// File: rtl/temp_code_encoder.sv
// Debounced 3-bit temperature-preset encoder: two-flop synchronizer, stable-count qualifier, registered code.
// switchTempPreven updates DEB_CYCLES+3 edges after a stable input change; code_stb follows for one cycle.
module temp_code_encoder #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw_raw,
  output logic [2:0] switchTempPreven,
  output logic       code_stb,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       cand;
  logic [2:0]       cand_nxt;
  logic [2:0]       code_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      sync1            <= 3'b000;
      sync2            <= 3'b000;
      cand             <= 3'b000;
      cnt              <= '0;
      switchTempPreven <= 3'b000;
    end else begin
      state            <= state_nxt;
      sync1            <= sw_raw;
      sync2            <= sync1;
      cand             <= cand_nxt;
      cnt              <= cnt_nxt;
      switchTempPreven <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    code_nxt  = switchTempPreven;
    unique case (state)
      IDLE: begin
        if (sync2 != switchTempPreven) begin
          cand_nxt  = sync2;
          cnt_nxt   = '0;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (sync2 == cand) begin
          if (cnt == CNT_LAST) begin
            code_nxt  = cand;
            state_nxt = COMMIT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else if (sync2 == switchTempPreven) begin
          // input bounced back to the committed code: abandon quietly
          state_nxt = IDLE;
        end else begin
          cand_nxt = sync2;
          cnt_nxt  = '0;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    code_stb = (state == COMMIT);
    busy     = (state != IDLE);
  end

endmodule
